// File: rtl/tipi_pkg.sv
// Shared constants and address helpers for the TIPI expansion-bus register file.
package tipi_pkg;

    localparam logic [15:0] TI_DSR_LO  = 16'h4000;
    localparam logic [15:0] TI_DSR_HI  = 16'h5FEF;
    localparam logic [3:0]  CRU_PREFIX = 4'h1;

    function automatic logic [15:0] reg_addr(input logic [15:0] top, input int idx);
        return top - 16'(2 * idx);
    endfunction

    // Register blocks grow downward in steps of two from their top address.
    function automatic bit map_ok(input int wr_top, input int nwr, input int rd_top, input int nrd);
        int wr_lo;
        int rd_lo;
        wr_lo = wr_top - 2 * (nwr - 1);
        rd_lo = rd_top - 2 * (nrd - 1);
        if (wr_lo <= rd_top && rd_lo <= wr_top)
            return 1'b0;
        if (wr_top >= int'(TI_DSR_LO) && wr_lo <= int'(TI_DSR_HI))
            return 1'b0;
        if (rd_top >= int'(TI_DSR_LO) && rd_lo <= int'(TI_DSR_HI))
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/tipi_sync.sv
// Multi-flop single-bit synchroniser with a configurable reset (idle) level.
module tipi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= {STAGES{RST_VAL}};
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tipi_bus_regs.sv
// TI-99/4A expansion-bus register file: synchronises the TI bus, latches write
// registers, tracks the CRU enable bit and decodes read-side output enables.
module tipi_bus_regs
    import tipi_pkg::*;
#(
    parameter int          NUM_WR      = 2,
    parameter int          NUM_RD      = 2,
    parameter logic [15:0] WR_TOP      = 16'h5FFF,
    parameter logic [15:0] RD_TOP      = 16'h5FFB,
    parameter int          SYNC_STAGES = 2,
    parameter int          REQUIRE_CRU = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [0:15]         ti_a,
    input  logic [0:7]          ti_data,
    input  logic                ti_memen,
    input  logic                ti_we,
    input  logic                ti_dbin,
    input  logic                ti_cruclk,
    input  logic                ti_reset,
    input  logic [3:0]          cru_base,
    output logic [8*NUM_WR-1:0] wr_regs,
    output logic [NUM_WR-1:0]   wr_strobe,
    output logic                cru_en,
    output logic                dsr_oe_n,
    output logic [NUM_RD-1:0]   rd_oe_n
);

    if (NUM_WR < 1 || NUM_RD < 1) begin : g_bad_count
        $error("tipi_bus_regs: NUM_WR and NUM_RD must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("tipi_bus_regs: SYNC_STAGES must be at least 2");
    end
    if (!map_ok(int'(WR_TOP), NUM_WR, int'(RD_TOP), NUM_RD)) begin : g_bad_map
        $error("tipi_bus_regs: register ranges overlap each other or the DSR window");
    end

    logic memen_s, we_s, dbin_s, cruclk_s, reset_s;

    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_memen
        (.clk(clk), .rst_n(rst_n), .d(ti_memen), .q(memen_s));
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_we
        (.clk(clk), .rst_n(rst_n), .d(ti_we), .q(we_s));
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dbin
        (.clk(clk), .rst_n(rst_n), .d(ti_dbin), .q(dbin_s));
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cruclk
        (.clk(clk), .rst_n(rst_n), .d(ti_cruclk), .q(cruclk_s));
    tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_reset
        (.clk(clk), .rst_n(rst_n), .d(ti_reset), .q(reset_s));

    // Sync stage: address/data delayed to line up with the synchronised controls
    logic [15:0] a_dly [SYNC_STAGES];
    logic [7:0]  d_dly [SYNC_STAGES];
    logic [15:0] a_s, a_p1;
    logic [7:0]  d_s, d_p1;

    always_ff @(posedge clk) begin
        a_dly[0] <= ti_a;
        d_dly[0] <= ti_data;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            a_dly[k] <= a_dly[k-1];
            d_dly[k] <= d_dly[k-1];
        end
        a_p1 <= a_s;
        d_p1 <= d_s;
    end

    assign a_s = a_dly[SYNC_STAGES-1];
    assign d_s = d_dly[SYNC_STAGES-1];

    // Stage p1: previous-cycle controls for edge detection
    logic memen_p1, we_p1, cruclk_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memen_p1  <= 1'b1;
            we_p1     <= 1'b1;
            cruclk_p1 <= 1'b1;
        end else begin
            memen_p1  <= memen_s;
            we_p1     <= we_s;
            cruclk_p1 <= cruclk_s;
        end
    end

    logic              dec_en, we_rise, cru_hit, dsr_hit;
    logic [NUM_WR-1:0] wr_hit;
    logic [NUM_RD-1:0] rd_hit;

    assign dec_en  = cru_en | (REQUIRE_CRU == 0);
    assign we_rise = ~we_p1 & we_s;

    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        cru_hit = 1'b0;
        dsr_hit = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            wr_hit[i] = we_rise & ~memen_p1 & dec_en & (a_p1 == reg_addr(WR_TOP, i));
        for (int j = 0; j < NUM_RD; j++)
            rd_hit[j] = ~memen_s & dbin_s & dec_en & (a_s == reg_addr(RD_TOP, j));
        cru_hit = cruclk_p1 & ~cruclk_s & (a_s[15:12] == CRU_PREFIX)
                & (a_s[11:8] == cru_base) & (a_s[7:1] == 7'd0);
        dsr_hit = ~memen_s & dbin_s & cru_en & (a_s >= TI_DSR_LO) & (a_s <= TI_DSR_HI);
    end

    // Output stage: TI reset overrides any same-cycle commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_regs   <= '0;
            wr_strobe <= '0;
            cru_en    <= 1'b0;
            dsr_oe_n  <= 1'b1;
            rd_oe_n   <= '1;
        end else if (!reset_s) begin
            wr_regs   <= '0;
            wr_strobe <= '0;
            cru_en    <= 1'b0;
            dsr_oe_n  <= 1'b1;
            rd_oe_n   <= '1;
        end else begin
            wr_strobe <= wr_hit;
            for (int i = 0; i < NUM_WR; i++)
                if (wr_hit[i])
                    wr_regs[8*i +: 8] <= d_p1;
            if (cru_hit)
                cru_en <= a_s[0];
            dsr_oe_n <= ~dsr_hit;
            rd_oe_n  <= ~rd_hit;
        end
    end

endmodule

// File: tb/tb_tipi_bus_regs.sv
// Self-checking bench for tipi_bus_regs: vector table plus strobe scoreboard.
module tb_tipi_bus_regs;

    localparam int LAT = 3;
    localparam int OP_CRU = 0, OP_WR = 1, OP_RD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:15] ti_a = '0;
    logic [0:7]  ti_data = '0;
    logic        ti_memen = 1'b1, ti_we = 1'b1, ti_dbin = 1'b0;
    logic        ti_cruclk = 1'b1, ti_reset = 1'b1;
    logic [3:0]  cru_base = 4'h1;
    logic [15:0] wr_regs;
    logic [1:0]  wr_strobe;
    logic        cru_en, dsr_oe_n;
    logic [1:0]  rd_oe_n;

    tipi_bus_regs dut (
        .clk(clk), .rst_n(rst_n), .ti_a(ti_a), .ti_data(ti_data),
        .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin),
        .ti_cruclk(ti_cruclk), .ti_reset(ti_reset), .cru_base(cru_base),
        .wr_regs(wr_regs), .wr_strobe(wr_strobe), .cru_en(cru_en),
        .dsr_oe_n(dsr_oe_n), .rd_oe_n(rd_oe_n)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  strobe;
        logic [15:0] regs;
        int          cyc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [1:0]  strobe;
        logic [15:0] regs;
        logic        cru;
        logic [1:0]  rd;
        logic        dsr;
        string       name;
    } vec_t;

    function automatic vec_t mk(int op, logic [15:0] addr, logic [7:0] data, logic [1:0] strobe,
                                logic [15:0] regs, logic cru, logic [1:0] rd, logic dsr, string name);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.strobe = strobe; v.regs = regs;
        v.cru = cru; v.rd = rd; v.dsr = dsr; v.name = name;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && wr_strobe != 2'b00) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: strobe=%b regs=%h at cyc %0d, none expected",
                         wr_strobe, wr_regs, cyc);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if (wr_strobe !== e.strobe || wr_regs !== e.regs || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe_event: got strobe=%b regs=%h cyc=%0d expected strobe=%b regs=%h cyc=%0d",
                             wr_strobe, wr_regs, cyc, e.strobe, e.regs, e.cyc);
                end
            end
        end
    end

    task automatic cru_op(input logic [15:0] a);
        @(negedge clk); ti_a = a;
        @(negedge clk); ti_cruclk = 1'b0;
        repeat (3) @(negedge clk);
        ti_cruclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ti_write(input logic [15:0] a, input logic [7:0] d,
                            input logic [1:0] strobe, input logic [15:0] regs);
        @(negedge clk); ti_a = a; ti_data = d; ti_memen = 1'b0;
        @(negedge clk); ti_we = 1'b0;
        repeat (8) @(negedge clk);
        ti_we = 1'b1;
        if (strobe != 2'b00) sbq.push_back('{strobe, regs, cyc + LAT});
        @(negedge clk); ti_memen = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic ti_read(input logic [15:0] a, input string nm,
                           input logic [1:0] rd, input logic dsr);
        @(negedge clk); ti_a = a; ti_memen = 1'b0; ti_dbin = 1'b1;
        repeat (5) @(negedge clk);
        chk({nm, "_rd_oe"}, 32'(rd_oe_n), 32'(rd));
        chk({nm, "_dsr_oe"}, 32'(dsr_oe_n), 32'(dsr));
        ti_memen = 1'b1; ti_dbin = 1'b0;
        repeat (5) @(negedge clk);
        chk({nm, "_oe_idle"}, {29'd0, dsr_oe_n, rd_oe_n}, 32'h7);
    endtask

    vec_t vt[15];

    initial begin
        vt[0]  = mk(OP_CRU, 16'h1101, 8'h00, 2'b00, 16'h0000, 1'b1, 2'b11, 1'b1, "cru_set");
        vt[1]  = mk(OP_CRU, 16'h1200, 8'h00, 2'b00, 16'h0000, 1'b1, 2'b11, 1'b1, "cru_other_base");
        vt[2]  = mk(OP_WR,  16'h5FFF, 8'hA5, 2'b01, 16'h00A5, 1'b1, 2'b11, 1'b1, "wr0_a5");
        vt[3]  = mk(OP_WR,  16'h5FFD, 8'h3C, 2'b10, 16'h3CA5, 1'b1, 2'b11, 1'b1, "wr1_3c");
        vt[4]  = mk(OP_WR,  16'h5FFD, 8'h3C, 2'b10, 16'h3CA5, 1'b1, 2'b11, 1'b1, "wr1_same");
        vt[5]  = mk(OP_WR,  16'h5FF0, 8'h11, 2'b00, 16'h3CA5, 1'b1, 2'b11, 1'b1, "wr_nomatch");
        vt[6]  = mk(OP_RD,  16'h5FFB, 8'h00, 2'b00, 16'h3CA5, 1'b1, 2'b10, 1'b1, "rd0");
        vt[7]  = mk(OP_RD,  16'h5FF9, 8'h00, 2'b00, 16'h3CA5, 1'b1, 2'b01, 1'b1, "rd1");
        vt[8]  = mk(OP_RD,  16'h4010, 8'h00, 2'b00, 16'h3CA5, 1'b1, 2'b11, 1'b0, "rd_dsr");
        vt[9]  = mk(OP_RD,  16'h5FF0, 8'h00, 2'b00, 16'h3CA5, 1'b1, 2'b11, 1'b1, "rd_gap");
        vt[10] = mk(OP_CRU, 16'h1100, 8'h00, 2'b00, 16'h3CA5, 1'b0, 2'b11, 1'b1, "cru_clear");
        vt[11] = mk(OP_WR,  16'h5FFF, 8'h77, 2'b00, 16'h3CA5, 1'b0, 2'b11, 1'b1, "wr_disabled");
        vt[12] = mk(OP_RD,  16'h5FFB, 8'h00, 2'b00, 16'h3CA5, 1'b0, 2'b11, 1'b1, "rd_disabled");
        vt[13] = mk(OP_RD,  16'h4010, 8'h00, 2'b00, 16'h3CA5, 1'b0, 2'b11, 1'b1, "dsr_disabled");
        vt[14] = mk(OP_CRU, 16'h1101, 8'h00, 2'b00, 16'h3CA5, 1'b1, 2'b11, 1'b1, "cru_reset");

        repeat (3) @(negedge clk);
        chk("rst_regs", 32'(wr_regs), 32'h0);
        chk("rst_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_cru", 32'(cru_en), 32'h0);
        chk("rst_oe", {29'd0, dsr_oe_n, rd_oe_n}, 32'h7);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int n = 0; n < 15; n++) begin
            case (vt[n].op)
                OP_CRU: cru_op(vt[n].addr);
                OP_WR:  ti_write(vt[n].addr, vt[n].data, vt[n].strobe, vt[n].regs);
                default: ti_read(vt[n].addr, vt[n].name, vt[n].rd, vt[n].dsr);
            endcase
            chk({vt[n].name, "_regs"}, 32'(wr_regs), 32'(vt[n].regs));
            chk({vt[n].name, "_cru"}, 32'(cru_en), 32'(vt[n].cru));
            chk({vt[n].name, "_sb_drain"}, sbq.size(), 0);
        end

        // TI reset held across the we rising edge of a matching write
        @(negedge clk); ti_a = 16'h5FFF; ti_data = 8'h5A; ti_memen = 1'b0;
        @(negedge clk); ti_we = 1'b0; ti_reset = 1'b0;
        repeat (8) @(negedge clk);
        ti_we = 1'b1;
        @(negedge clk); ti_memen = 1'b1;
        repeat (4) @(negedge clk);
        ti_reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("tireset_regs", 32'(wr_regs), 32'h0);
        chk("tireset_cru", 32'(cru_en), 32'h0);
        chk("tireset_oe", {29'd0, dsr_oe_n, rd_oe_n}, 32'h7);
        chk("tireset_sb_drain", sbq.size(), 0);

        cru_op(16'h1101);
        chk("reenable_cru", 32'(cru_en), 32'h1);
        ti_write(16'h5FFF, 8'h96, 2'b01, 16'h0096);
        chk("pre_rstn_regs", 32'(wr_regs), 32'h0096);

        // rst_n asserted while we is low; the edge after release must be lost
        @(negedge clk); ti_a = 16'h5FFD; ti_data = 8'h42; ti_memen = 1'b0;
        @(negedge clk); ti_we = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstn_regs", 32'(wr_regs), 32'h0);
        chk("rstn_strobe", 32'(wr_strobe), 32'h0);
        chk("rstn_cru", 32'(cru_en), 32'h0);
        chk("rstn_oe", {29'd0, dsr_oe_n, rd_oe_n}, 32'h7);
        @(negedge clk); ti_we = 1'b1;
        repeat (2) @(negedge clk);
        ti_memen = 1'b1; rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rstn_regs", 32'(wr_regs), 32'h0);
        chk("post_rstn_sb_drain", sbq.size(), 0);

        cru_op(16'h1101);
        ti_write(16'h5FFD, 8'hC3, 2'b10, 16'hC300);
        chk("first_write_regs", 32'(wr_regs), 32'hC300);
        chk("first_write_sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded 2 ms, expected completion");
        $fatal(1);
    end

endmodule
